// File: rtl/qu_pkg.sv
// Shared types for the Qu reservation station: entry payload and the "no producer" tag.
package qu_pkg;

   localparam int unsigned QU_RF_WIDTH = 32;
   localparam int unsigned QU_QI_WIDTH = 6;
   localparam int unsigned QU_OP_WIDTH = 5;

   localparam logic [QU_QI_WIDTH-1:0] QI_NONE = '0;

   typedef struct packed {
      logic                   busy;
      logic [QU_OP_WIDTH-1:0] op;
      logic [QU_QI_WIDTH-1:0] tag;
      logic [QU_RF_WIDTH-1:0] vj;
      logic [QU_QI_WIDTH-1:0] qj;
      logic [QU_RF_WIDTH-1:0] vk;
      logic [QU_QI_WIDTH-1:0] qk;
   } rs_entry_t;

endpackage

// File: rtl/rs_select.sv
// Issue picker: one-hot grant over ready entries. Oldest-first when QU_RS_OLDEST_FIRST_EN
// is defined (age matrix input), otherwise lowest index.
module rs_select #(
   parameter int unsigned DEPTH = 4
) (
   input  logic [DEPTH-1:0]       i_ready,
`ifdef QU_RS_OLDEST_FIRST_EN
   input  logic [DEPTH*DEPTH-1:0] i_age,
`endif
   output logic [DEPTH-1:0]       o_grant_c,
   output logic                   o_valid_c
);

`ifdef QU_RS_OLDEST_FIRST_EN
   // i_age[j*DEPTH+i] set means entry j is older than entry i
   always_comb begin : oldest_pick
      logic blocked;
      o_grant_c = '0;
      for (int i = 0; i < DEPTH; i++) begin
         blocked = 1'b0;
         for (int j = 0; j < DEPTH; j++) begin
            if (j != i && i_ready[j] && i_age[j*DEPTH+i]) blocked = 1'b1;
         end
         o_grant_c[i] = i_ready[i] && !blocked;
      end
   end
`else
   always_comb begin : lowest_pick
      logic found;
      o_grant_c = '0;
      found     = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (i_ready[i] && !found) begin
            o_grant_c[i] = 1'b1;
            found        = 1'b1;
         end
      end
   end
`endif

   assign o_valid_c = |i_ready;

endmodule

// File: rtl/rs_unit.sv
// Reservation station: holds dispatched ops, snoops the CDB, issues ready ops through a
// registered valid/ready port. Define QU_RS_OLDEST_FIRST_EN for oldest-first selection.
module rs_unit
   import qu_pkg::*;
#(
   parameter int unsigned RS_DEPTH = 4,
   parameter int unsigned RF_WIDTH = QU_RF_WIDTH,
   parameter int unsigned QI_WIDTH = QU_QI_WIDTH,
   parameter int unsigned OP_WIDTH = QU_OP_WIDTH
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush,
   input  logic                          disp_valid,
   output logic                          disp_ready,
   input  logic [OP_WIDTH-1:0]           disp_op,
   input  logic [QI_WIDTH-1:0]           disp_tag,
   input  logic [RF_WIDTH-1:0]           disp_vj,
   input  logic [RF_WIDTH-1:0]           disp_vk,
   input  logic [QI_WIDTH-1:0]           disp_qj,
   input  logic [QI_WIDTH-1:0]           disp_qk,
   input  logic                          cdb_valid,
   input  logic [QI_WIDTH-1:0]           cdb_tag,
   input  logic [RF_WIDTH-1:0]           cdb_data,
   output logic                          iss_valid,
   input  logic                          iss_ready,
   output logic [OP_WIDTH-1:0]           iss_op,
   output logic [QI_WIDTH-1:0]           iss_tag,
   output logic [RF_WIDTH-1:0]           iss_vj,
   output logic [RF_WIDTH-1:0]           iss_vk,
   output logic [$clog2(RS_DEPTH+1)-1:0] rs_count
);

   localparam int unsigned CNT_W = $clog2(RS_DEPTH + 1);

   rs_entry_t            r_ent     [RS_DEPTH];
   rs_entry_t            w_ent_nxt [RS_DEPTH];
   rs_entry_t            w_sel;
   logic [RS_DEPTH-1:0]  w_ready;
   logic [RS_DEPTH-1:0]  w_free_oh;
   logic [RS_DEPTH-1:0]  w_grant;
   logic                 w_grant_valid;
   logic                 w_disp_fire;
   logic                 w_iss_load;
   logic [CNT_W-1:0]     w_count_nxt;
   logic [CNT_W-1:0]     r_count;
   logic                 r_disp_ready;
   logic                 r_iss_valid;
   logic [OP_WIDTH-1:0]  r_iss_op;
   logic [QI_WIDTH-1:0]  r_iss_tag;
   logic [RF_WIDTH-1:0]  r_iss_vj;
   logic [RF_WIDTH-1:0]  r_iss_vk;

   always_comb begin : ready_vec
      for (int i = 0; i < RS_DEPTH; i++) begin
         w_ready[i] = r_ent[i].busy && (r_ent[i].qj == QI_NONE) && (r_ent[i].qk == QI_NONE);
      end
   end

   always_comb begin : free_pick
      logic found;
      w_free_oh = '0;
      found     = 1'b0;
      for (int i = 0; i < RS_DEPTH; i++) begin
         if (!r_ent[i].busy && !found) begin
            w_free_oh[i] = 1'b1;
            found        = 1'b1;
         end
      end
   end

`ifdef QU_RS_OLDEST_FIRST_EN
   logic [RS_DEPTH*RS_DEPTH-1:0] r_age;

   // New entry becomes younger than every other entry
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_age <= '0;
      end else if (w_disp_fire) begin
         for (int a = 0; a < RS_DEPTH; a++) begin
            if (w_free_oh[a]) begin
               for (int j = 0; j < RS_DEPTH; j++) begin
                  r_age[a*RS_DEPTH+j] <= 1'b0;
                  if (j != a) r_age[j*RS_DEPTH+a] <= 1'b1;
               end
            end
         end
      end
   end

   rs_select #(.DEPTH(RS_DEPTH)) u_select (
      .i_ready   (w_ready),
      .i_age     (r_age),
      .o_grant_c (w_grant),
      .o_valid_c (w_grant_valid)
   );
`else
   rs_select #(.DEPTH(RS_DEPTH)) u_select (
      .i_ready   (w_ready),
      .o_grant_c (w_grant),
      .o_valid_c (w_grant_valid)
   );
`endif

   assign w_disp_fire = disp_valid && r_disp_ready && !flush;
   assign w_iss_load  = (!r_iss_valid || iss_ready) && w_grant_valid && !flush;

   always_comb begin : sel_mux
      w_sel = '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
         if (w_grant[i]) w_sel = r_ent[i];
      end
   end

   // Per-entry update: snoop, free on issue, allocate with CDB bypass, flush last
   always_comb begin : ent_next
      for (int i = 0; i < RS_DEPTH; i++) begin
         w_ent_nxt[i] = r_ent[i];
         if (r_ent[i].busy && cdb_valid && cdb_tag != QI_NONE) begin
            if (r_ent[i].qj == cdb_tag) begin
               w_ent_nxt[i].vj = cdb_data;
               w_ent_nxt[i].qj = QI_NONE;
            end
            if (r_ent[i].qk == cdb_tag) begin
               w_ent_nxt[i].vk = cdb_data;
               w_ent_nxt[i].qk = QI_NONE;
            end
         end
         if (w_iss_load && w_grant[i]) w_ent_nxt[i].busy = 1'b0;
         if (w_disp_fire && w_free_oh[i]) begin
            w_ent_nxt[i].busy = 1'b1;
            w_ent_nxt[i].op   = disp_op;
            w_ent_nxt[i].tag  = disp_tag;
            w_ent_nxt[i].vj   = disp_vj;
            w_ent_nxt[i].qj   = disp_qj;
            w_ent_nxt[i].vk   = disp_vk;
            w_ent_nxt[i].qk   = disp_qk;
            if (cdb_valid && disp_qj != QI_NONE && cdb_tag == disp_qj) begin
               w_ent_nxt[i].vj = cdb_data;
               w_ent_nxt[i].qj = QI_NONE;
            end
            if (cdb_valid && disp_qk != QI_NONE && cdb_tag == disp_qk) begin
               w_ent_nxt[i].vk = cdb_data;
               w_ent_nxt[i].qk = QI_NONE;
            end
         end
         if (flush) w_ent_nxt[i].busy = 1'b0;
      end
   end

   assign w_count_nxt = flush ? '0
                              : r_count + CNT_W'(w_disp_fire) - CNT_W'(w_iss_load);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < RS_DEPTH; i++) r_ent[i] <= '0;
         r_count      <= '0;
         r_disp_ready <= 1'b1;
      end else begin
         for (int i = 0; i < RS_DEPTH; i++) r_ent[i] <= w_ent_nxt[i];
         r_count      <= w_count_nxt;
         r_disp_ready <= (w_count_nxt != CNT_W'(RS_DEPTH));
      end
   end

   // Issue register: holds while stalled, drops valid after handshake with nothing ready
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_iss_valid <= 1'b0;
         r_iss_op    <= '0;
         r_iss_tag   <= '0;
         r_iss_vj    <= '0;
         r_iss_vk    <= '0;
      end else if (flush) begin
         r_iss_valid <= 1'b0;
      end else if (w_iss_load) begin
         r_iss_valid <= 1'b1;
         r_iss_op    <= w_sel.op;
         r_iss_tag   <= w_sel.tag;
         r_iss_vj    <= w_sel.vj;
         r_iss_vk    <= w_sel.vk;
      end else if (iss_ready) begin
         r_iss_valid <= 1'b0;
      end
   end

   assign disp_ready = r_disp_ready;
   assign rs_count   = r_count;
   assign iss_valid  = r_iss_valid;
   assign iss_op     = r_iss_op;
   assign iss_tag    = r_iss_tag;
   assign iss_vj     = r_iss_vj;
   assign iss_vk     = r_iss_vk;

`ifndef SYNTHESIS
   a_disp_tag_nonzero : assert property (@(posedge clk) disable iff (!rst)
      (disp_valid && disp_ready && !flush) |-> (disp_tag != QI_NONE));
`endif

endmodule

// File: doc/rs_unit.md
# rs_unit

Reservation station for one functional unit of the Qu out-of-order core. Sits directly downstream of the register file: the dispatch stage reads operand data and producer tags (Qi) from the register file and writes them here. Entries snoop the common data bus (CDB) until both operands are valid, then issue to the functional unit through a registered valid/ready port. Tag value 0 means "operand valid", matching the register file's Qi encoding.

## Interface
- RS_DEPTH, 4, number of entries (power of two, ≥2)
- RF_WIDTH, 32, operand data width
- QI_WIDTH, 6, producer tag width; tag 0 = no producer
- OP_WIDTH, 5, micro-op field width, opaque to this block
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  synchronous squash of all entries and issue register
- disp_valid  in  1  dispatch request
- disp_ready  out  1  a free entry exists (registered state only)
- disp_op  in  OP_WIDTH  micro-op
- disp_tag  in  QI_WIDTH  destination tag of this instruction (non-zero)
- disp_vj, disp_vk  in  RF_WIDTH  operand data from register file
- disp_qj, disp_qk  in  QI_WIDTH  operand producer tags from register file
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  QI_WIDTH  broadcasting tag
- cdb_data  in  RF_WIDTH  broadcast result
- iss_valid  out  1  issue register holds an instruction
- iss_ready  in  1  functional unit accepts
- iss_op  out  OP_WIDTH; iss_tag  out  QI_WIDTH; iss_vj, iss_vk  out  RF_WIDTH  issued fields
- rs_count  out  $clog2(RS_DEPTH+1)  number of busy entries

## Operation
- Entry state: busy, op, tag, vj, qj, vk, qk. Ready = busy && qj==0 && qk==0 (registered values).
- Reset: all busy=0, iss_valid=0, iss_op/iss_tag/iss_vj/iss_vk=0, rs_count=0, disp_ready=1.
- Dispatch accepted when disp_valid && disp_ready && !flush; allocates lowest-index free entry.
- Dispatch-cycle bypass: if cdb_valid && cdb_tag==disp_qj (disp_qj≠0), store cdb_data in vj and qj=0; same for k.
- Snoop: every busy entry with qj==cdb_tag (≠0) and cdb_valid captures cdb_data, clears qj; same for k. cdb_tag 0 never matches.
- Issue register loads when (!iss_valid || iss_ready) and a ready entry exists; selected entry freed that cycle. Otherwise iss_* hold stable (standard valid/ready: no change while iss_valid && !iss_ready).
- Selection: see Configuration.
- rs_count = +1 on accepted dispatch, −1 on entry moved to issue register; both same cycle → unchanged.
- flush: all busy=0, iss_valid=0, rs_count=0 next cycle; overrides dispatch, snoop and issue in that cycle.
- disp_tag==0 is illegal; assertion in simulation.

## Timing
- Dispatch with both tags 0 at cycle t: entry busy at t+1, iss_valid at t+2 (if issue register free).
- CDB wakeup at cycle t: operand valid at t+1, earliest iss_valid at t+2.
- Full: disp_ready=0 even if an entry frees this cycle; goes to 1 the cycle after.
- rst asserted mid-operation: immediate return to reset values, no handshake completed.

## Configuration
- QU_RS_OLDEST_FIRST_EN defined: per-entry age matrix updated on allocation; oldest ready entry selected.
- Undefined: lowest-index ready entry selected; age matrix not instantiated.

## Structure
- qu_pkg: rs_entry_t struct (busy, op, tag, vj, qj, vk, qk), QI_NONE='0 constant.
- Sub-module rs_select: takes ready vector (and age matrix when enabled), returns one-hot grant and valid.

## Test plan
- Dispatch op=3, tag=5, vj=10, vk=20, qj=qk=0 → iss_valid at t+2, iss_tag=5, iss_vj=10, iss_vk=20.
- Dispatch qj=7; CDB tag 7 data 0xABCD two cycles later → iss_vj=0xABCD two cycles after broadcast.
- Dispatch qk=9 with cdb_valid, cdb_tag=9, cdb_data=0x55 same cycle → entry ready, iss_vk=0x55.
- Fill 4 entries with pending tags, iss_ready=0 → disp_ready=0, rs_count=4; wake one, hold iss_ready=0 → iss_* stable.
- Entries 2 then 0 dispatched, both woken same cycle → with macro tag of entry 2 issues first, without entry 0 first.
- flush with 3 busy and iss_valid=1 → next cycle rs_count=0, iss_valid=0, disp_ready=1.
